// File: rtl/ring_counter_pkg.sv
// Shared constants for the shift-register counter family.
package ring_counter_pkg;

    // Counter flavour selected by the mode input.
    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    // Shift direction selected by the dir input.
    localparam logic DIR_LEFT  = 1'b0;  // toward MSB
    localparam logic DIR_RIGHT = 1'b1;  // toward LSB

endpackage

// File: rtl/ring_state_check.sv
// Legality detector for ring (one-hot) and Johnson (thermometer) states.
// Shared by the valid flag and the self-correction path of the counter,
// and usable by any other sequencer built on the same state encodings.
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    input  logic             mode,
    output logic             legal
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_inv;
    logic             w_onehot;
    logic             w_low_therm;
    logic             w_high_therm;

    // Classify the state: one-hot, low thermometer (0..01..1) or high thermometer (1..10..0).
    always_comb begin
        w_inv        = ~state;
        // x & (x-1) clears the lowest set bit; zero result with x != 0 means one bit set.
        w_onehot     = (state != '0) && ((state & (state - ONE)) == '0);
        // x & (x+1) is zero only when x is a run of ones anchored at the LSB (or zero).
        w_low_therm  = ((state & (state + ONE)) == '0);
        // The complement of a high thermometer code is a low thermometer code.
        w_high_therm = ((w_inv & (w_inv + ONE)) == '0);
        if (mode == MODE_JOHNSON) begin
            legal = w_low_therm || w_high_therm;
        end else begin
            legal = w_onehot;
        end
    end

endmodule

// File: rtl/param_ring_counter.sv
// Parametrised ring / Johnson counter with direction control, parallel load,
// self-correction of illegal states, a legality flag and a wrap pulse.
module param_ring_counter
    import ring_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_POS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             wrap
);

    // Reject configurations that have no meaningful one-hot reset pattern.
    generate
        if (WIDTH < 2 || RESET_POS < 0 || RESET_POS >= WIDTH) begin : g_bad_params
            $error("param_ring_counter: need WIDTH >= 2 and 0 <= RESET_POS < WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] RING_HOME = {{(WIDTH-1){1'b0}}, 1'b1} << RESET_POS;

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_home;
    logic [WIDTH-1:0] w_shift;
    logic             w_fill_left;
    logic             w_fill_right;
    logic             w_legal;

    ring_state_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .state (r_count),
        .mode  (mode),
        .legal (w_legal)
    );

    // Home pattern and the one-step shifted value for the current mode and direction.
    always_comb begin
        w_home       = (mode == MODE_JOHNSON) ? '0 : RING_HOME;
        // Johnson mode feeds back the inverted outgoing bit; ring mode feeds it back as is.
        w_fill_left  = (mode == MODE_JOHNSON) ? ~r_count[WIDTH-1] : r_count[WIDTH-1];
        w_fill_right = (mode == MODE_JOHNSON) ? ~r_count[0]       : r_count[0];
        if (dir == DIR_LEFT) begin
            w_shift = {r_count[WIDTH-2:0], w_fill_left};
        end else begin
            w_shift = {w_fill_right, r_count[WIDTH-1:1]};
        end
    end

    // State register: reset > load > correction/shift on enable > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            // The reset pattern is the ring home in both modes; in Johnson mode
            // it is a legal LSB/MSB one-hot only when RESET_POS is an end bit.
            r_count <= RING_HOME;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_wrap  <= 1'b0;
        end else if (enable) begin
            if (!w_legal) begin
                r_count <= w_home;
                r_wrap  <= 1'b0;
            end else begin
                r_count <= w_shift;
                r_wrap  <= (w_shift == w_home);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign valid = w_legal;

endmodule

// File: tb/tb_param_ring_counter.sv
// Bench for param_ring_counter: a 4-bit (RESET_POS=0) and an 8-bit (RESET_POS=3)
// instance driven one cycle at a time against an independent behavioural model.
module tb_param_ring_counter;

    logic clk;

    logic       a_reset, a_enable, a_mode, a_dir, a_load;
    logic [3:0] a_load_val, a_count;
    logic       a_valid, a_wrap;

    logic       b_reset, b_enable, b_mode, b_dir, b_load;
    logic [7:0] b_load_val, b_count;
    logic       b_valid, b_wrap;

    // Expected {wrap, valid, count} per driven cycle.
    logic [33:0] exp_q[$];

    int n_total = 0;
    int n_bad   = 0;

    int          wid   [2] = '{4, 8};
    int          rpos  [2] = '{0, 3};
    logic [31:0] m_count[2];

    param_ring_counter #(.WIDTH(4), .RESET_POS(0)) u_dut_a (
        .clk      (clk),
        .reset    (a_reset),
        .enable   (a_enable),
        .mode     (a_mode),
        .dir      (a_dir),
        .load     (a_load),
        .load_val (a_load_val),
        .count    (a_count),
        .valid    (a_valid),
        .wrap     (a_wrap)
    );

    param_ring_counter #(.WIDTH(8), .RESET_POS(3)) u_dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .enable   (b_enable),
        .mode     (b_mode),
        .dir      (b_dir),
        .load     (b_load),
        .load_val (b_load_val),
        .count    (b_count),
        .valid    (b_valid),
        .wrap     (b_wrap)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] low_mask(input int k);
        if (k >= 32) return '1;
        return (32'd1 << k) - 32'd1;
    endfunction

    // Legality by enumeration: count the ones, or list every thermometer code.
    function automatic bit model_legal(input logic [31:0] c, input int w, input bit m);
        int ones;
        if (!m) begin
            ones = 0;
            for (int i = 0; i < w; i++) ones += int'(c[i]);
            return ones == 1;
        end
        for (int k = 0; k <= w; k++) begin
            if (c == low_mask(k)) return 1'b1;
            if (c == (low_mask(w) ^ low_mask(w - k))) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive one cycle on instance sel, predict its outcome, then compare after the edge.
    task automatic step(input int sel, input bit rst, input bit en, input bit md,
                        input bit dr, input bit ld, input logic [31:0] lv, input string tag);
        logic [31:0] c, nc, home, msk;
        logic        nw;
        logic [33:0] e;
        int          w;
        w    = wid[sel];
        msk  = low_mask(w);
        c    = m_count[sel];
        home = md ? 32'd0 : (32'd1 << rpos[sel]);
        nw   = 1'b0;
        if (rst) begin
            nc = 32'd1 << rpos[sel];
        end else if (ld) begin
            nc = lv & msk;
        end else if (en) begin
            if (!model_legal(c, w, md)) begin
                nc = home;
            end else begin
                if (!dr) nc = ((c << 1) | 32'(md ^ c[w-1])) & msk;
                else     nc = (c >> 1) | (32'(md ^ c[0]) << (w - 1));
                nw = (nc == home);
            end
        end else begin
            nc = c;
        end
        m_count[sel] = nc;
        exp_q.push_back({nw, model_legal(nc, w, md), nc});

        if (sel == 0) begin
            a_reset = rst; a_enable = en; a_mode = md; a_dir = dr; a_load = ld;
            a_load_val = lv[3:0];
        end else begin
            b_reset = rst; b_enable = en; b_mode = md; b_dir = dr; b_load = ld;
            b_load_val = lv[7:0];
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (sel == 0) begin
            check({tag, ".count"}, 32'(a_count), e[31:0]);
            check({tag, ".valid"}, 32'(a_valid), 32'(e[32]));
            check({tag, ".wrap"},  32'(a_wrap),  32'(e[33]));
        end else begin
            check({tag, ".count"}, 32'(b_count), e[31:0]);
            check({tag, ".valid"}, 32'(b_valid), 32'(e[32]));
            check({tag, ".wrap"},  32'(b_wrap),  32'(e[33]));
        end
    endtask

    logic [3:0] ring_left_tbl [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                      4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] johnson_tbl   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                      4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        bit md, dr;
        a_reset = 1'b1; a_enable = 1'b0; a_mode = 1'b0; a_dir = 1'b0; a_load = 1'b0; a_load_val = '0;
        b_reset = 1'b1; b_enable = 1'b0; b_mode = 1'b0; b_dir = 1'b0; b_load = 1'b0; b_load_val = '0;
        m_count[0] = '0;
        m_count[1] = '0;
        @(negedge clk);

        // Reset state of both instances.
        step(0, 1, 0, 0, 0, 0, 0, "a_reset");
        step(1, 1, 0, 0, 0, 0, 0, "b_reset");
        check("b_reset_pattern", 32'(b_count), 32'h08);

        // Ring left, cross-checked against a literal table.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 0, 0, 0, "ring_left");
            check("ring_left_tbl", 32'(a_count), 32'(ring_left_tbl[i]));
        end

        // Ring right from 0001, then hold with enable low.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0, 0, "ring_right");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "hold");

        // Johnson left from 0000, two full periods.
        step(0, 0, 0, 1, 0, 1, 32'h0, "j_load");
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 1, 0, 0, 0, "johnson_left");
            check("johnson_tbl", 32'(a_count), 32'(johnson_tbl[i % 8]));
        end

        // Self-correction of illegal states.
        step(0, 0, 0, 0, 0, 1, 32'h0, "ring_zero_load");
        step(0, 0, 1, 0, 0, 0, 0,     "ring_zero_fix");
        step(0, 0, 0, 0, 0, 1, 32'h6, "ring_0110_load");
        step(0, 0, 0, 0, 0, 0, 0,     "illegal_persist");
        step(0, 0, 1, 0, 0, 0, 0,     "ring_0110_fix");
        step(0, 0, 0, 1, 0, 1, 32'h5, "j_0101_load");
        step(0, 0, 1, 1, 0, 0, 0,     "j_0101_fix");

        // Priority: load beats enable; reset beats load.
        step(0, 0, 1, 0, 0, 1, 32'h4, "load_over_enable");
        step(0, 1, 1, 0, 0, 1, 32'h8, "reset_over_load");

        // Reset in the middle of a Johnson period.
        step(0, 0, 0, 1, 0, 1, 32'h0, "j_mid_load");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0, "j_mid_run");
        step(0, 1, 1, 1, 0, 0, 0, "j_mid_reset");

        // Ring MSB one-hot is legal in Johnson mode and shifts into home.
        step(0, 0, 0, 0, 0, 1, 32'h8, "mode_sw_load");
        step(0, 0, 1, 1, 0, 0, 0,     "mode_sw_shift");

        // Randomised mix of all controls.
        md = 1'b0;
        dr = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) md = ~md;
            if ($urandom_range(0, 7) == 0) dr = ~dr;
            step(0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, md, dr,
                 $urandom_range(0, 9) == 0, 32'($urandom_range(0, 15)), "a_rand");
        end

        // Wide instance: one full ring period back to 00001000 with one wrap.
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 0, 0, "b_ring_left");
        check("b_home_after_period", 32'(b_count), 32'h08);
        for (int i = 0; i < 16; i++) step(1, 0, 1, 1, 1, 0, 0, "b_johnson_right");
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 9) == 0) md = ~md;
            if ($urandom_range(0, 7) == 0) dr = ~dr;
            step(1, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, md, dr,
                 $urandom_range(0, 9) == 0, 32'($urandom_range(0, 255)), "b_rand");
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/param_ring_counter.md
# param_ring_counter

Parametrised shift-register counter that generalises the 4-bit one-hot ring counter. It adds configurable width, a Johnson (twisted-ring) mode, left and right direction, parallel load, self-correction of illegal states, a legality flag and a wrap pulse. It sits in the sequential-counter library as the standard sequencer and one-hot phase generator for downstream datapath blocks.

## Interface
- WIDTH, 4, register width; legal range 2..32.
- RESET_POS, 0, bit position of the single '1' in the ring reset pattern; legal range 0..WIDTH-1.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance one step per cycle when high.
- mode  in  1  0 = ring (one-hot), 1 = Johnson.
- dir  in  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value captured on load.
- count  out  WIDTH  counter state (registered).
- valid  out  1  high when count is a legal state for the current mode (combinational from count and mode).
- wrap  out  1  one-cycle registered pulse marking completion of a full period.

## Operation
- Home pattern:
  - ring: one-hot with bit RESET_POS set.
  - Johnson: all zeros.
- Legal states:
  - ring: exactly one bit set.
  - Johnson: thermometer codes of the form 0…01…1 or 1…10…0, including all-zeros and all-ones (2·WIDTH states).
- Next-state priority, evaluated each rising edge:
  1. reset: count <= 1<<RESET_POS, wrap <= 0. This applies regardless of mode.
  2. load: count <= load_val verbatim, even if illegal; wrap <= 0.
  3. enable with illegal count: count <= home pattern of the current mode; wrap <= 0. This is the self-correction path.
  4. enable with legal count, ring mode:
     - dir=0: count <= {count[W-2:0], count[W-1]}
     - dir=1: count <= {count[0], count[W-1:1]}
  5. enable with legal count, Johnson mode:
     - dir=0: count <= {count[W-2:0], ~count[W-1]}
     - dir=1: count <= {~count[0], count[W-1:1]}
  6. Otherwise: hold count; wrap <= 0.
- wrap <= 1 only on a normal shift (rules 4 and 5) whose result equals the home pattern of the current mode.
- Periods:
  - ring: WIDTH enabled cycles between wraps.
  - Johnson: 2·WIDTH enabled cycles between wraps.
- Mode or direction change mid-run:
  - Takes effect on the next shift.
  - Any state that is illegal in the new mode is corrected on the next enabled cycle.
  - A ring state is legal in Johnson mode only if it is the LSB or MSB one-hot.
- All-zeros in ring mode (the classic lock-up state) is illegal and is always corrected.

## Timing
- Reset values: count = 1<<RESET_POS, wrap = 0. valid follows count and mode (1 after reset in ring mode).
- Latency: count changes on the rising edge after enable, load or reset is sampled high.
- wrap is high in the same cycle that count shows the home pattern produced by a shift.
- valid has zero latency: it is combinational from count and mode.
- Simultaneous events:
  - load and enable both high: load wins.
  - reset high: overrides load and enable.
- Reset mid-period: count returns to home on the next edge, with no wrap pulse.
- An illegal state persists with enable low; valid stays 0 until corrected or reloaded.

## Structure
- Package ring_counter_pkg holds:
  - the mode constants (MODE_RING = 1'b0, MODE_JOHNSON = 1'b1);
  - the direction constants (DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1).
- One sub-module, ring_state_check (parameter WIDTH; inputs state and mode; output legal):
  - provides the legality detector shared by valid and the correction path;
  - is reusable by other sequencers.
- Parameter checks:
  - elaboration-time error if WIDTH < 2 or RESET_POS >= WIDTH.

## Test plan
- Ring left (WIDTH=4, RESET_POS=0):
  - reset, then enable for 8 cycles -> count 0010, 0100, 1000, 0001, …
  - wrap high exactly when count = 0001, every 4th cycle; valid = 1 throughout.
- Ring right:
  - dir=1 from 0001 -> 1000, 0100, 0010, 0001, with wrap on 0001.
  - enable low for 3 cycles -> count holds, wrap = 0.
- Johnson left (WIDTH=4):
  - load 0000 with mode=1, then enable -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - wrap pulses on each return to 0000 (period 8).
- Self-correction:
  - ring mode, load 0000 -> valid = 0; next enabled cycle -> 0001, valid = 1, wrap = 0.
  - load 0110 -> the same correction to 0001.
  - Johnson mode, load 0101 -> corrected to 0000.
- Priority and reset:
  - load = 1, enable = 1, load_val = 0100 -> count = 0100.
  - reset asserted with load = 1 -> count = 0001.
  - reset mid-Johnson at 0111 -> 0001 next edge, wrap = 0.
- Parametrised instance (WIDTH=8, RESET_POS=3):
  - reset -> 00001000.
  - 8 left shifts -> returns to 00001000 with a single wrap pulse.
